mem_bank_sim: RTL
=================

# mem_bank_sim

Single-bank, word-addressed memory with a fixed response latency. It models one SRAM bank behind the memory-stream master of the AXI-to-memory bridge, and one instance connects to each bank output. It accepts requests through a req/gnt handshake and returns exactly one rvalid per accepted request, including writes. It executes AXI ATOP load and swap operations as a two-cycle read-modify-write. An optional pseudo-random grant-stall generator exercises bridge backpressure.

## Interface
- AddrWidth, 32: byte-address width of `addr_i`.
- DataWidth, 32: word width. Multiple of 8.
- NumWords, 1024: depth. Power of two, ≥2.
- Latency, 1: cycles from acceptance to `rvalid_o`. Must be ≥1. Bridge BufDepth must be ≥ Latency.
- StallSeed, 16'hACE1: reset value of the stall LFSR. Must be non-zero. Used only with MEM_BANK_STALL_EN.
- clk_i  in  1  clock; all logic is rising-edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted this cycle when `req_i & gnt_o`.
- addr_i  in  AddrWidth  byte address.
- wdata_i  in  DataWidth  write or operand data.
- strb_i  in  DataWidth/8  byte enables.
- atop_i  in  6  `axi_pkg::atop_t`.
- we_i  in  1  write enable.
- rvalid_o  out  1  response valid, single-cycle pulse.
- rdata_o  out  DataWidth  response data.

## Operation
- Word index = `addr_i[$clog2(DataWidth/8) +: $clog2(NumWords)]`. Upper bits are ignored, so addresses wrap. Byte-offset bits are ignored.
- Plain read (`atop_i==0`, `!we_i`): the response carries `mem[idx]` as sampled at acceptance.
- Plain write (`atop_i==0`, `we_i`): bytes with a set strobe are written at the acceptance edge. The response carries `rdata_o='0`.
- `strb_i=='0` with `we_i`: no array change. A response is still returned.
- ATOP handling when `atop_i!=0`; `we_i` is ignored:
  - AtomicSwap (6'b110000): new = wdata.
  - AtomicLoad or AtomicStore (atop[5:4] = 2'b10 or 2'b01) with op atop[2:0]:
    - 0 ADD: new = old + wdata, two's complement, truncated to DataWidth.
    - 1 CLR: new = old & ~wdata.
    - 2 EOR: new = old ^ wdata.
    - 3 SET: new = old | wdata.
  - Ops 4–7 (MAX/MIN) and AtomicCompare: no write, old data returned.
  - Strobes mask the write of `new`.
  - The response always carries `old`.
- FSM:
  - IDLE: `gnt_o = !stall`. An accepted supported ATOP latches idx, new and strb, then goes to AMO_WR.
  - AMO_WR: `gnt_o=0`. The latched data is written and the FSM returns to IDLE.
- Response path: a Latency-deep shift register of {valid, data}. It never stalls; there is no `rready`.

## Timing
- Acceptance at edge t → `rvalid_o` high in the cycle after edge t+Latency−1, i.e. Latency cycles later. Throughput is one request per cycle.
- ATOP: accepted at t, write at t+1, `gnt_o` low for the one cycle between. The response follows the normal Latency.
- Read-after-write to the same word in the next cycle returns the new data. A read accepted in the cycle immediately after an ATOP (earliest t+2) sees the ATOP result.
- `gnt_o` is combinational from the FSM state and the stall bit only. It never depends on `req_i`.
- Reset values: `gnt_o` is 1 (0 if a stall is active at reset), `rvalid_o` 0, `rdata_o` '0, FSM IDLE, LFSR = StallSeed.
- Array contents are not reset.
- Reset mid-operation: in-flight responses are dropped, and a pending AMO_WR write is discarded.

## Configuration
- `MEM_BANK_STALL_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
  - `stall = (lfsr[1:0]==2'b00)`, roughly 25% grant denial.
  - Requests are never lost; the requester holds them.
- Undefined: `stall` is constant 0, there is no LFSR, and StallSeed is unused.

## Structure
- `mem_bank_pkg` holds:
  - the state enum {IDLE, AMO_WR};
  - ATOP decode constants;
  - `function amo_compute(atop, old, operand)` returning {new, do_write}.
- Sub-module `mem_bank_resp_pipe` is the Latency-stage valid/data shift register.

## Test plan
- Write addr 0x10, data 0xDEADBEEF, strb 4'hF, then read 0x10 → the write gets `rvalid_o` with data 0. With Latency=1 the read gets 0xDEADBEEF on the following `rvalid_o`.
- Partial strobe: mem 0x11223344, write 0xAABBCCDD with strb 4'b0101 → a read returns 0x11BB33DD.
- AtomicLoad ADD: mem 0xFFFFFFFF, operand 2:
  - the response is 0xFFFFFFFF;
  - `gnt_o` is 0 for exactly one cycle;
  - a later read returns 0x00000001.
- Address wrap with NumWords=1024 and DataWidth=32: write to 0x1004, then read 0x0004 → the written value is returned.
- Latency=3, back-to-back reads of words 0..7 → `rvalid_o` is high in 8 consecutive cycles starting 3 cycles after the first acceptance, data in order.
- Assert `rst_i` while 2 responses are in flight → no `rvalid_o` after reset. With `MEM_BANK_STALL_EN`, 1000 random requests all receive exactly one response each.

Source files
------------

// File: rtl/mem_bank_pkg.sv
// mem_bank_pkg: FSM state, ATOP decode constants and the read-modify-write helper for mem_bank_sim.
package mem_bank_pkg;
   typedef enum logic {IDLE, AMO_WR} state_t;
   localparam int AmoWidth = 256;
   localparam logic [5:0] ATOP_SWAP = 6'b110000;
   localparam logic [1:0] ATOP_LOAD = 2'b10;
   localparam logic [1:0] ATOP_STORE = 2'b01;
   localparam logic [2:0] AMO_ADD = 3'd0;
   localparam logic [2:0] AMO_CLR = 3'd1;
   localparam logic [2:0] AMO_EOR = 3'd2;
   // Operands arrive zero-extended to AmoWidth; callers keep the low DataWidth bits of the result.
   function automatic logic [AmoWidth:0] amo_compute(input logic [5:0] atop, input logic [AmoWidth-1:0] old,
                                                      input logic [AmoWidth-1:0] operand);
      logic [AmoWidth-1:0] nv;
      logic wr;
      nv = old;
      wr = 1'b0;
      if (atop == ATOP_SWAP) begin
         nv = operand;
         wr = 1'b1;
      end else if ((atop[5:4] == ATOP_LOAD || atop[5:4] == ATOP_STORE) && !atop[2]) begin
         wr = 1'b1;
         nv = atop[2:0] == AMO_ADD ? old + operand :
              atop[2:0] == AMO_CLR ? old & ~operand :
              atop[2:0] == AMO_EOR ? old ^ operand : old | operand;
      end
      return {nv, wr};
   endfunction
endpackage

// File: rtl/mem_bank_sim_if.sv
// mem_bank_sim_if: req/gnt memory request bus with fixed-latency response.
interface mem_bank_sim_if #(parameter int AddrWidth = 32, parameter int DataWidth = 32);
   logic req;
   logic gnt;
   logic [AddrWidth-1:0] addr;
   logic [DataWidth-1:0] wdata;
   logic [DataWidth/8-1:0] strb;
   logic [5:0] atop;
   logic we;
   logic rvalid;
   logic [DataWidth-1:0] rdata;
   modport master (output req, addr, wdata, strb, atop, we, input gnt, rvalid, rdata);
   modport slave (input req, addr, wdata, strb, atop, we, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_bank_resp_pipe.sv
// mem_bank_resp_pipe: Latency-stage valid/data shift register carrying bank responses.
module mem_bank_resp_pipe #(
   parameter int DataWidth = 32,
   parameter int Latency = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic push,
   input  logic [DataWidth-1:0] push_data,
   output logic rvalid,
   output logic [DataWidth-1:0] rdata
);
   logic [Latency-1:0] vld;
   logic [DataWidth-1:0] dat [Latency];
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         vld <= '0;
         for (int i = 0; i < Latency; i++) dat[i] <= '0;
      end else begin
         vld[0] <= push;
         dat[0] <= push_data;
         for (int i = 1; i < Latency; i++) begin
            vld[i] <= vld[i-1];
            dat[i] <= dat[i-1];
         end
      end
   assign rvalid = vld[Latency-1];
   assign rdata = dat[Latency-1];
endmodule

// File: rtl/mem_bank_sim.sv
// mem_bank_sim: single-bank word memory with fixed-latency responses and two-cycle ATOP read-modify-write.
// Define MEM_BANK_STALL_EN to add the pseudo-random grant-stall LFSR.
module mem_bank_sim
   import mem_bank_pkg::*;
#(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32,
   parameter int NumWords = 1024,
   parameter int Latency = 1,
   parameter logic [15:0] StallSeed = 16'hACE1
) (
   input logic clk_i,
   input logic rst_i,
   mem_bank_sim_if.slave bus
);
   localparam int NB = DataWidth / 8;
   localparam int OW = $clog2(NB);
   localparam int IW = $clog2(NumWords);
   if (Latency < 1 || NumWords < 2 || (NumWords & (NumWords - 1)) != 0 || DataWidth % 8 != 0 ||
       DataWidth > AmoWidth || StallSeed == 16'h0) begin : g_bad_cfg
      $error("mem_bank_sim: invalid parameter set");
   end
   state_t state;
   logic stall, accept, is_amo, amo_ok, amo_wr, wr_en;
   logic [IW-1:0] idx, amo_idx, wr_idx;
   logic [DataWidth-1:0] old, amo_new, amo_data, wr_data, resp_data;
   logic [NB-1:0] amo_strb, wr_strb;
   logic [DataWidth-1:0] mem [NumWords];
`ifdef MEM_BANK_STALL_EN
   logic [15:0] lfsr;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) lfsr <= StallSeed;
      else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign stall = lfsr[1:0] == 2'b00;
`else
   assign stall = 1'b0;
`endif
   assign idx = bus.addr[OW +: IW];
   assign old = mem[idx];
   assign is_amo = bus.atop != '0;
   assign bus.gnt = state == IDLE && !stall;
   assign accept = bus.req && bus.gnt;
   assign amo_ok = 1'(amo_compute(bus.atop, AmoWidth'(old), AmoWidth'(bus.wdata)));
   assign amo_new = DataWidth'(amo_compute(bus.atop, AmoWidth'(old), AmoWidth'(bus.wdata)) >> 1);
   assign amo_wr = state == AMO_WR;
   // Grant is withheld in AMO_WR, so the latched ATOP write never collides with a plain write.
   assign wr_en = !rst_i && (amo_wr || (accept && !is_amo && bus.we));
   assign wr_idx = amo_wr ? amo_idx : idx;
   assign wr_data = amo_wr ? amo_data : bus.wdata;
   assign wr_strb = amo_wr ? amo_strb : bus.strb;
   assign resp_data = is_amo || !bus.we ? old : '0;
   always_ff @(posedge clk_i)
      if (wr_en)
         for (int b = 0; b < NB; b++)
            if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state <= IDLE;
         amo_idx <= '0;
         amo_data <= '0;
         amo_strb <= '0;
      end else if (amo_wr) begin
         state <= IDLE;
      end else if (accept && is_amo && amo_ok) begin
         state <= AMO_WR;
         amo_idx <= idx;
         amo_data <= amo_new;
         amo_strb <= bus.strb;
      end
   mem_bank_resp_pipe #(.DataWidth(DataWidth), .Latency(Latency)) u_resp_pipe (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .push(accept),
      .push_data(resp_data),
      .rvalid(bus.rvalid),
      .rdata(bus.rdata)
   );
endmodule
